// File: rtl/food_placer_pkg.sv
// food_placer shared types and default playfield geometry.
// Optional scan fallback is enabled with FOOD_PLACER_SCAN_FALLBACK_EN.
package food_placer_pkg;

  localparam int DEF_GRID_W    = 10;
  localparam int DEF_GRID_H    = 10;
  localparam int DEF_COORD_W   = 4;
  localparam int DEF_MAX_TRIES = 8;
  localparam int GRID_CELLS    = DEF_GRID_W * DEF_GRID_H;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    WAIT,
    SCAN,
    DONE,
    FAIL
  } state_e;

endpackage

// File: rtl/food_placer_stepper.sv
// grid_cell_stepper: loadable row-major x/y walker with wrap-around.
// wrapped_all marks the last cell of one full lap since the load.
import food_placer_pkg::*;

module grid_cell_stepper #(
  parameter int GRID_W  = DEF_GRID_W,
  parameter int GRID_H  = DEF_GRID_H,
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] ld_x,
  input  logic [COORD_W-1:0] ld_y,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               wrapped_all
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int CNT_W = $clog2(CELLS);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] base_x, base_y;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // load and step together land on the cell after the loaded one
  always_comb begin
    base_x = load ? ld_x : x_q;
    base_y = load ? ld_y : y_q;
    x_d    = base_x;
    y_d    = base_y;
    if (step) begin
      if (base_x == COORD_W'(GRID_W - 1)) begin
        x_d = '0;
        if (base_y == COORD_W'(GRID_H - 1)) y_d = '0;
        else y_d = base_y + 1'b1;
      end else begin
        x_d = base_x + 1'b1;
      end
    end
    cnt_d = cnt_q;
    if (load) cnt_d = '0;
    else if (step) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign wrapped_all = (cnt_q == CNT_W'(CELLS - 1));

endmodule

// File: rtl/food_placer.sv
// food_placer: random-sample food placement against the occupancy map.
// Define FOOD_PLACER_SCAN_FALLBACK_EN to scan the grid after MAX_TRIES misses.
import food_placer_pkg::*;

module food_placer #(
  parameter int GRID_W    = DEF_GRID_W,
  parameter int GRID_H    = DEF_GRID_H,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               place_req,
  output logic               busy,
  input  logic [COORD_W-1:0] rnd_x,
  input  logic [COORD_W-1:0] rnd_y,
  output logic               probe_valid,
  output logic [COORD_W-1:0] probe_x,
  output logic [COORD_W-1:0] probe_y,
  input  logic               probe_occupied,
  output logic               done,
  output logic               fail,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_e             state_q, state_d;
  logic [TRY_W-1:0]   try_q, try_d, try_inc;
  logic [COORD_W-1:0] probe_x_q, probe_x_d;
  logic [COORD_W-1:0] probe_y_q, probe_y_d;
  logic [COORD_W-1:0] food_x_q, food_x_d;
  logic [COORD_W-1:0] food_y_q, food_y_d;
  logic               pv, done_c, fail_c, rnd_bad, last_try;

`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
  logic               scan_q, scan_d;
  logic               st_load, st_step, st_wrap;
  logic [COORD_W-1:0] st_ld_x, st_ld_y, st_x, st_y;

  grid_cell_stepper #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .COORD_W(COORD_W)
  ) u_stepper (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (st_load),
    .step       (st_step),
    .ld_x       (st_ld_x),
    .ld_y       (st_ld_y),
    .x          (st_x),
    .y          (st_y),
    .wrapped_all(st_wrap)
  );
`endif

  assign try_inc  = try_q + 1'b1;
  assign last_try = (try_inc == TRY_W'(MAX_TRIES));
  assign rnd_bad  = (rnd_x >= COORD_W'(GRID_W)) |
                    (rnd_y >= COORD_W'(GRID_H));

  always_comb begin
    state_d   = state_q;
    try_d     = try_q;
    probe_x_d = probe_x_q;
    probe_y_d = probe_y_q;
    food_x_d  = food_x_q;
    food_y_d  = food_y_q;
    pv        = 1'b0;
    done_c    = 1'b0;
    fail_c    = 1'b0;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
    scan_d  = scan_q;
    st_load = 1'b0;
    st_step = 1'b0;
    st_ld_x = probe_x_q;
    st_ld_y = probe_y_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (place_req) begin
          state_d = SAMPLE;
          try_d   = '0;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
          scan_d  = 1'b0;
`endif
        end
      end
      SAMPLE: begin
        if (rnd_bad) begin
          try_d = try_inc;
          if (last_try) begin
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
            // no valid last probe: lap starts at the origin
            state_d = SCAN;
            scan_d  = 1'b1;
            st_load = 1'b1;
            st_ld_x = '0;
            st_ld_y = '0;
`else
            state_d = FAIL;
`endif
          end
        end else begin
          pv        = 1'b1;
          probe_x_d = rnd_x;
          probe_y_d = rnd_y;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (!probe_occupied) begin
          food_x_d = probe_x_q;
          food_y_d = probe_y_q;
          state_d  = DONE;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
        end else if (scan_q) begin
          if (st_wrap) begin
            state_d = FAIL;
          end else begin
            st_step = 1'b1;
            state_d = SCAN;
          end
`endif
        end else begin
          try_d = try_inc;
          if (last_try) begin
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
            state_d = SCAN;
            scan_d  = 1'b1;
            st_load = 1'b1;
            st_step = 1'b1;
`else
            state_d = FAIL;
`endif
          end else begin
            state_d = SAMPLE;
          end
        end
      end
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
      SCAN: begin
        pv        = 1'b1;
        probe_x_d = st_x;
        probe_y_d = st_y;
        state_d   = WAIT;
      end
`endif
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        fail_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      try_q     <= '0;
      probe_x_q <= '0;
      probe_y_q <= '0;
      food_x_q  <= '0;
      food_y_q  <= '0;
    end else begin
      state_q   <= state_d;
      try_q     <= try_d;
      probe_x_q <= probe_x_d;
      probe_y_q <= probe_y_d;
      food_x_q  <= food_x_d;
      food_y_q  <= food_y_d;
    end
  end

`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scan_q <= 1'b0;
    else scan_q <= scan_d;
  end
`endif

  // probe coords follow the sample in its strobe cycle, then hold
  assign probe_valid = pv;
  assign probe_x     = probe_x_d;
  assign probe_y     = probe_y_d;
  assign busy        = (state_q != IDLE);
  assign done        = done_c;
  assign fail        = fail_c;
  assign food_x      = food_x_q;
  assign food_y      = food_y_q;

endmodule
